// File: rtl/led_blinker_pkg.sv
// Shared types for the multi-channel LED blinker: channel modes and per-channel control state.
package led_blinker_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_BURST = 2'd3
  } mode_e;

  typedef struct packed {
    mode_e mode;
    logic  phase;  // 1 = on phase of a BLINK/BURST cycle
    logic  done;   // registered burst completion pulse
  } ch_ctrl_t;

  localparam ch_ctrl_t CH_CTRL_RST = '{mode: MODE_OFF, phase: 1'b0, done: 1'b0};

  function automatic logic is_running(input mode_e m);
    return (m == MODE_BLINK) || (m == MODE_BURST);
  endfunction

  function automatic logic pin_level(input logic lit, input logic active_low);
    return lit ^ active_low;
  endfunction

endpackage

// File: rtl/blink_channel.sv
// One LED channel: half-period counter, on/off phase, burst countdown and pin polarity.
module blink_channel
  import led_blinker_pkg::*;
#(
  parameter int unsigned CNT_W               = 26,
  parameter int unsigned BURST_W             = 8,
  parameter int unsigned DEFAULT_HALF_PERIOD = 25_000_000,
  parameter bit          ACTIVE_LOW          = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_i,
  input  logic [1:0]         mode_i,
  input  logic [CNT_W-1:0]   half_period_i,
  input  logic [BURST_W-1:0] burst_len_i,
  input  logic               sync_i,
  output logic               led_o,
  output logic               burst_active_o,
  output logic               burst_done_o
);

  ch_ctrl_t           ctrl_q, ctrl_d;
  logic [CNT_W-1:0]   half_q, half_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BURST_W-1:0] rem_q, rem_d;
  logic               terminal;

  assign terminal = (cnt_q == (half_q - CNT_W'(1)));

  // Priority: config write, then sync realign, then normal counting.
  always_comb begin
    ctrl_d      = ctrl_q;
    half_d      = half_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    ctrl_d.done = 1'b0;
    if (wr_i) begin
      ctrl_d.mode  = mode_e'(mode_i);
      ctrl_d.phase = 1'b1;
      half_d       = (half_period_i == '0) ? CNT_W'(1) : half_period_i;
      cnt_d        = '0;
      rem_d        = burst_len_i;
      if ((mode_e'(mode_i) == MODE_BURST) && (burst_len_i == '0)) begin
        ctrl_d.mode = MODE_OFF;
        ctrl_d.done = 1'b1;
      end
    end else if (is_running(ctrl_q.mode)) begin
      if (sync_i) begin
        cnt_d        = '0;
        ctrl_d.phase = 1'b1;
      end else if (terminal) begin
        cnt_d        = '0;
        ctrl_d.phase = ~ctrl_q.phase;
        // A burst pulse is counted when its on phase ends.
        if ((ctrl_q.mode == MODE_BURST) && ctrl_q.phase && (rem_q != '0)) begin
          rem_d = rem_q - BURST_W'(1);
          if (rem_q == BURST_W'(1)) begin
            ctrl_d.mode = MODE_OFF;
            ctrl_d.done = 1'b1;
          end
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q <= CH_CTRL_RST;
      half_q <= CNT_W'(DEFAULT_HALF_PERIOD);
      cnt_q  <= '0;
      rem_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      half_q <= half_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
    end
  end

  assign led_o = pin_level((ctrl_q.mode == MODE_ON) ||
                           (is_running(ctrl_q.mode) && ctrl_q.phase), ACTIVE_LOW);
  assign burst_active_o = (ctrl_q.mode == MODE_BURST);
  assign burst_done_o   = ctrl_q.done;

endmodule

// File: rtl/multi_led_blinker.sv
// Multi-channel LED blinker top: decodes config writes to one channel and broadcasts sync.
module multi_led_blinker
  import led_blinker_pkg::*;
#(
  parameter int unsigned N_CH                = 4,
  parameter int unsigned CNT_W               = 26,
  parameter int unsigned BURST_W             = 8,
  parameter int unsigned DEFAULT_HALF_PERIOD = 25_000_000,
  parameter bit          ACTIVE_LOW          = 1'b1,
  localparam int unsigned CH_W               = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [1:0]         cfg_mode,
  input  logic [CNT_W-1:0]   cfg_half_period,
  input  logic [BURST_W-1:0] cfg_burst_len,
  input  logic               sync,
  output logic [N_CH-1:0]    led,
  output logic [N_CH-1:0]    burst_active,
  output logic [N_CH-1:0]    burst_done
);

  // Indices at or above N_CH never match, so such writes are dropped.
  for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
    logic wr;
    assign wr = cfg_valid && (cfg_ch == CH_W'(i));

    blink_channel #(
      .CNT_W              (CNT_W),
      .BURST_W            (BURST_W),
      .DEFAULT_HALF_PERIOD(DEFAULT_HALF_PERIOD),
      .ACTIVE_LOW         (ACTIVE_LOW)
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .wr_i          (wr),
      .mode_i        (cfg_mode),
      .half_period_i (cfg_half_period),
      .burst_len_i   (cfg_burst_len),
      .sync_i        (sync),
      .led_o         (led[i]),
      .burst_active_o(burst_active[i]),
      .burst_done_o  (burst_done[i])
    );
  end

endmodule

// File: tb/tb_multi_led_blinker.sv
// Directed bench for multi_led_blinker: vector table plus hand-written corner sequences.
module tb_multi_led_blinker;

  localparam int unsigned CW = 26;
  localparam int unsigned BW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic [1:0]    cfg_ch;
  logic [1:0]    cfg_mode;
  logic [CW-1:0] cfg_half_period;
  logic [BW-1:0] cfg_burst_len;
  logic          sync;
  logic [3:0]    led, burst_active, burst_done;

  logic          c3_valid;
  logic [1:0]    c3_ch;
  logic [1:0]    c3_mode;
  logic [2:0]    led3, ba3, done3;

  always #5 clk = ~clk;

  multi_led_blinker u_dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_half_period(cfg_half_period), .cfg_burst_len(cfg_burst_len), .sync(sync),
    .led(led), .burst_active(burst_active), .burst_done(burst_done)
  );

  multi_led_blinker #(.N_CH(3)) u_dut3 (
    .clk(clk), .rst(rst), .cfg_valid(c3_valid), .cfg_ch(c3_ch), .cfg_mode(c3_mode),
    .cfg_half_period(26'd3), .cfg_burst_len(8'd0), .sync(1'b0),
    .led(led3), .burst_active(ba3), .burst_done(done3)
  );

  typedef struct {
    string         tag;
    logic          v;
    logic [1:0]    ch;
    logic [1:0]    mode;
    logic [CW-1:0] hp;
    logic [BW-1:0] len;
    logic          sy;
    logic [3:0]    e_led;
    logic [3:0]    e_ba;
    logic [3:0]    e_done;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] ch, input logic [1:0] mode,
                       input logic [CW-1:0] hp, input logic [BW-1:0] len, input logic sy);
    cfg_valid = v; cfg_ch = ch; cfg_mode = mode;
    cfg_half_period = hp; cfg_burst_len = len; sync = sy;
  endtask

  task automatic idle_in();
    drive(1'b0, 2'd0, 2'd0, '0, '0, 1'b0);
  endtask

  task automatic add(input string tag, input logic v, input logic [1:0] ch,
                     input logic [1:0] mode, input logic [CW-1:0] hp, input logic [BW-1:0] len,
                     input logic sy, input logic [3:0] e_led, input logic [3:0] e_ba,
                     input logic [3:0] e_done);
    vec_t t;
    t.tag = tag; t.v = v; t.ch = ch; t.mode = mode; t.hp = hp; t.len = len; t.sy = sy;
    t.e_led = e_led; t.e_ba = e_ba; t.e_done = e_done;
    vq.push_back(t);
  endtask

  task automatic add_idle(input string tag, input int n, input logic [3:0] e_led,
                          input logic [3:0] e_ba, input logic [3:0] e_done);
    for (int i = 0; i < n; i++) add(tag, 1'b0, 2'd0, 2'd0, '0, '0, 1'b0, e_led, e_ba, e_done);
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    c3_valid = 1'b0; c3_ch = 2'd0; c3_mode = 2'd0;

    // Reset: held three cycles, then idle for 100.
    repeat (3) tick();
    check("rst_led", led, 4'b1111);
    check("rst_ba", burst_active, 4'b0000);
    check("rst_done", burst_done, 4'b0000);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      check("idle_led", led, 4'b1111);
      check("idle_done", burst_done | burst_active, 4'b0000);
    end

    // BLINK ch0, H=3
    add("blink_wr", 1, 2'd0, 2'd2, 26'd3, 8'd0, 0, 4'b1110, 4'b0000, 4'b0000);
    add_idle("blink_on0", 2, 4'b1110, 4'b0000, 4'b0000);
    add_idle("blink_off", 3, 4'b1111, 4'b0000, 4'b0000);
    add_idle("blink_on1", 3, 4'b1110, 4'b0000, 4'b0000);
    add("blink_stop", 1, 2'd0, 2'd0, 26'd3, 8'd0, 0, 4'b1111, 4'b0000, 4'b0000);
    // BURST ch1, H=3, L=2
    add("burst_wr", 1, 2'd1, 2'd3, 26'd3, 8'd2, 0, 4'b1101, 4'b0010, 4'b0000);
    add_idle("burst_on0", 2, 4'b1101, 4'b0010, 4'b0000);
    add_idle("burst_off0", 3, 4'b1111, 4'b0010, 4'b0000);
    add_idle("burst_on1", 3, 4'b1101, 4'b0010, 4'b0000);
    add_idle("burst_end", 1, 4'b1111, 4'b0000, 4'b0010);
    add_idle("burst_quiet", 31, 4'b1111, 4'b0000, 4'b0000);
    // Zero burst length on ch2
    add("len0_wr", 1, 2'd2, 2'd3, 26'd5, 8'd0, 0, 4'b1111, 4'b0000, 4'b0100);
    add_idle("len0_after", 1, 4'b1111, 4'b0000, 4'b0000);
    // Zero half-period on ch3 toggles every cycle
    add("hp0_wr", 1, 2'd3, 2'd2, 26'd0, 8'd0, 0, 4'b0111, 4'b0000, 4'b0000);
    add_idle("hp0_c1", 1, 4'b1111, 4'b0000, 4'b0000);
    add_idle("hp0_c2", 1, 4'b0111, 4'b0000, 4'b0000);
    add_idle("hp0_c3", 1, 4'b1111, 4'b0000, 4'b0000);
    // Sync coinciding with terminal count on ch3, H=2
    add("synct_wr", 1, 2'd3, 2'd2, 26'd2, 8'd0, 0, 4'b0111, 4'b0000, 4'b0000);
    add_idle("synct_c1", 1, 4'b0111, 4'b0000, 4'b0000);
    add("synct_sync", 0, 2'd0, 2'd0, 26'd0, 8'd0, 1, 4'b0111, 4'b0000, 4'b0000);
    add_idle("synct_on", 1, 4'b0111, 4'b0000, 4'b0000);
    add_idle("synct_off", 2, 4'b1111, 4'b0000, 4'b0000);
    add_idle("synct_on2", 1, 4'b0111, 4'b0000, 4'b0000);
    add("synct_stop", 1, 2'd3, 2'd0, 26'd2, 8'd0, 0, 4'b1111, 4'b0000, 4'b0000);

    foreach (vq[i]) begin
      drive(vq[i].v, vq[i].ch, vq[i].mode, vq[i].hp, vq[i].len, vq[i].sy);
      tick();
      check({vq[i].tag, "_led"}, led, vq[i].e_led);
      check({vq[i].tag, "_ba"}, burst_active, vq[i].e_ba);
      check({vq[i].tag, "_done"}, burst_done, vq[i].e_done);
    end
    idle_in();

    // Sync alignment: ch0 and ch2 (H=4) started two cycles apart
    drive(1'b1, 2'd0, 2'd2, 26'd4, 8'd0, 1'b0); tick();
    idle_in(); tick(); tick();
    drive(1'b1, 2'd2, 2'd2, 26'd4, 8'd0, 1'b0); tick();
    idle_in(); repeat (10) tick();
    drive(1'b0, 2'd0, 2'd0, '0, '0, 1'b1); tick();
    idle_in();
    for (int c = 0; c < 16; c++) begin
      logic exp_bit;
      if (c > 0) tick();
      exp_bit = ((c / 4) % 2 == 0) ? 1'b0 : 1'b1;
      check("sync_ch0", led[0], exp_bit);
      check("sync_ch2", led[2], exp_bit);
    end
    drive(1'b1, 2'd0, 2'd0, 26'd4, 8'd0, 1'b0); tick();
    drive(1'b1, 2'd2, 2'd0, 26'd4, 8'd0, 1'b0); tick();
    idle_in();
    check("sync_stop", led, 4'b1111);

    // ON written to ch1 mid-burst aborts it silently
    drive(1'b1, 2'd1, 2'd3, 26'd3, 8'd3, 1'b0); tick();
    idle_in(); repeat (3) tick();
    check("abort_pre_led", led, 4'b1111);
    drive(1'b1, 2'd1, 2'd1, 26'd3, 8'd3, 1'b0); tick();
    idle_in();
    check("abort_ba", burst_active, 4'b0000);
    for (int i = 0; i < 15; i++) begin
      check("abort_led", led, 4'b1101);
      check("abort_done", burst_done, 4'b0000);
      tick();
    end
    drive(1'b1, 2'd1, 2'd0, 26'd3, 8'd0, 1'b0); tick();

    // cfg and sync on the same edge: cfg wins
    drive(1'b1, 2'd1, 2'd2, 26'd10, 8'd0, 1'b0); tick();
    idle_in(); repeat (3) tick();
    drive(1'b1, 2'd1, 2'd3, 26'd2, 8'd1, 1'b1); tick();
    idle_in();
    check("cs_led0", led, 4'b1101);
    check("cs_ba0", burst_active, 4'b0010);
    tick();
    check("cs_led1", led, 4'b1101);
    tick();
    check("cs_led2", led, 4'b1111);
    check("cs_done2", burst_done, 4'b0010);
    check("cs_ba2", burst_active, 4'b0000);
    tick();
    check("cs_done3", burst_done, 4'b0000);

    // rst at the edge that would have ended a single-pulse burst
    drive(1'b1, 2'd1, 2'd3, 26'd3, 8'd1, 1'b0); tick();
    idle_in(); tick(); tick();
    check("rstb_pre", led, 4'b1101);
    rst = 1'b1; tick();
    check("rstb_led", led, 4'b1111);
    check("rstb_ba", burst_active, 4'b0000);
    check("rstb_done", burst_done, 4'b0000);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rstb_after", {burst_done, led}, {4'b0000, 4'b1111});
    end

    // Out-of-range channel index on the 3-channel instance
    c3_valid = 1'b1; c3_ch = 2'd3; c3_mode = 2'd1; tick();
    check("oor_led", led3, 3'b111);
    check("oor_ba", ba3 | done3, 3'b000);
    c3_ch = 2'd2; tick();
    c3_valid = 1'b0;
    check("inrange_led", led3, 3'b011);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
